// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply, restoring divide, valid/ready in and out.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand ops bypass the iteration and complete in one cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [XLEN-1:0]    opnd;
    logic [2*XLEN-1:0]  acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;
    logic               neg_rem;

    logic               is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic               div_by_zero, div_ovf, early;
    logic [XLEN-1:0]    abs_a, abs_b, special_res;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Operand decode at accept: signedness, magnitudes and the cases that skip iteration.
    always_comb begin
        is_div      = op[2];
        a_sgn       = is_div ? !op[0] : (op[1:0] != 2'b11);
        b_sgn       = is_div ? !op[0] : !op[1];
        a_neg       = a_sgn & a[XLEN-1];
        b_neg       = b_sgn & b[XLEN-1];
        abs_a       = a_neg ? -a : a;
        abs_b       = b_neg ? -b : b;
        div_by_zero = is_div & (b == '0);
        div_ovf     = is_div & !op[0] & (a == MIN_VAL) & (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early       = is_div ? ((a == '0) & (b != '0)) : ((a == '0) | (b == '0));
`else
        early       = 1'b0;
`endif
        special_res = '0;
        if (div_by_zero)
            special_res = op[1] ? a : '1;
        else if (div_ovf)
            special_res = op[1] ? '0 : a;
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? div_shift[2*XLEN-1:0]
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod      = neg_res ? -acc : acc;
        quo       = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd       = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            cnt       <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            opnd      <= '0;
            acc       <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q    <= op;
                    tag_q   <= in_tag;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    if (div_by_zero | div_ovf | early) begin
                        result    <= special_res;
                        out_tag   <= in_tag;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        opnd  <= is_div ? abs_b : abs_a;
                        acc   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                        cnt   <= CNT_W'(XLEN);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= op_q[2] ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= FIX;
                end
                FIX: begin
                    result    <= fix_res;
                    out_tag   <= tag_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake/reset sequences, random ops vs arithmetic model.
// Honours MULDIV_EARLY_OUT_EN when computing expected latency.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp_res;
    } vec_t;

    // Plain-arithmetic reference for RV32M semantics.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && x == 0) return 1;
        if (!f[2] && (x == 0 || y == 0)) return 1;
`endif
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic startOp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        @(negedge clk);
        op = f; a = x; b = y; in_tag = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = $urandom(); a = $urandom(); b = $urandom(); in_tag = $urandom();
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("in_ready_after_ack", {63'b0, in_ready}, 64'd1);
        checkOutput("out_valid_after_ack", {63'b0, out_valid}, 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int lat;
        startOp(v.op, v.a, v.b, v.tag);
        waitValid(lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(exp_latency(v.op, v.a, v.b)));
        checkOutput({name, "_result"}, {32'b0, result}, {32'b0, v.exp_res});
        checkOutput({name, "_tag"}, {59'b0, out_tag}, {59'b0, v.tag});
        checkOutput({name, "_in_ready_done"}, {63'b0, in_ready}, 64'd0);
        releaseResult();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[14];
        vec_t v;
        int   lat;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2};
        vecs[8]  = '{3'd5, 32'd100,        32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd100,        32'd0,         5'd10, 32'd100};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
        vecs[12] = '{3'd0, 32'd0,          32'd12345,     5'd13, 32'd0};
        vecs[13] = '{3'd4, 32'd0,          32'd5,         5'd14, 32'd0};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset_result", {32'b0, result}, 64'd0);
        checkOutput("reset_out_tag", {59'b0, out_tag}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] DONE hold and ignored in_valid");
        startOp(3'd0, 32'd6, 32'd7, 5'd3);
        @(negedge clk);
        op = 3'd5; a = 32'd9; b = 32'd3; in_tag = 5'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("hold_valid_seen", {63'b0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_result", {32'b0, result}, 64'd42);
            checkOutput("hold_tag", {59'b0, out_tag}, 64'd3);
            checkOutput("hold_in_ready", {63'b0, in_ready}, 64'd0);
            checkOutput("hold_out_valid", {63'b0, out_valid}, 64'd1);
        end
        releaseResult();

        $display("[TB] reset during CALC");
        startOp(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("calc_busy", {63'b0, busy}, 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("midreset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("midreset_result", {32'b0, result}, 64'd0);
        checkOutput("midreset_tag", {59'b0, out_tag}, 64'd0);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            v.op      = 3'($urandom_range(0, 7));
            v.a       = pick_operand();
            v.b       = pick_operand();
            v.tag     = 5'($urandom());
            v.exp_res = ref_model(v.op, v.a, v.b);
            applyStimulus(v, $sformatf("rand%0d_op%0d", i, v.op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
